electron_nest: RTL and testbench

- Top-level compute tile with two external-memory ports: a load port and a store port, both carrying forward/backward tokens (FTk_t/BTk_t from pkg_en).
- After a boot stream delivers a configuration block over the load port, the tile runs a vector multiply-multiply kernel: St[k] = A[k] * B[k] * K for k = 0..N-1.
- The tile sits directly behind the external memory / testbench memory model.

---
 rtl/pkg_en.sv | 23 ++
 rtl/electron_nest.sv | 144 ++++++++++++++
 tb/tb_electron_nest.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkg_en.sv
// Token types shared by the electron_nest load/store memory ports.
package pkg_en;

  localparam int FTK_D_W = 32;
  localparam int FTK_I_W = 8;

  typedef struct packed {
    logic               v;
    logic               a;
    logic               r;
    logic               c;
    logic [FTK_I_W-1:0] i;
    logic [FTK_D_W-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

endpackage

// File: rtl/electron_nest.sv
// Compute tile: boots a config block over the load port, then stores
// St[k] = A[k] * B[k] * K (unsigned, truncated) for k = 0..N-1.
module electron_nest #(
  parameter int WIDTH_DATA   = pkg_en::FTK_D_W,
  parameter int WIDTH_EXADDR = 16,
  parameter int WIDTH_INDEX  = pkg_en::FTK_I_W,
  parameter int BOOT_HDR     = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  output logic                    O_Ld_Req,
  output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
  input  pkg_en::FTk_t            I_Ld_FTk,
  output pkg_en::BTk_t            O_Ld_BTk,
  output logic                    O_St_Req,
  output logic [WIDTH_EXADDR-1:0] O_St_Addr,
  output pkg_en::FTk_t            O_St_FTk,
  input  pkg_en::BTk_t            I_St_BTk
);

  localparam int CNT_W = $clog2(BOOT_HDR + 6);

  typedef enum logic [3:0] {
    S_IDLE, S_BOOT, S_LD_A, S_WT_A, S_LD_B, S_WT_B, S_MUL, S_ST, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        boot_cnt;
  logic [CNT_W-1:0]        cfg_sel;
  logic [WIDTH_EXADDR-1:0] abase, bbase, sbase;
  logic [WIDTH_DATA-1:0]   n_len, k_mul, k_idx, k_nxt;
  logic [WIDTH_DATA-1:0]   ra_p0, rb_p0, prod_p1;
  logic                    ld_vld, boot_last, st_done;

  function automatic logic [WIDTH_DATA-1:0] mul_trunc(
    input logic [WIDTH_DATA-1:0] x,
    input logic [WIDTH_DATA-1:0] y
  );
    return x * y;
  endfunction

  logic unused_inputs;
  assign unused_inputs = ^{I_Boot, I_Ld_FTk.r, I_Ld_FTk.c, I_Ld_FTk.i,
                           I_St_BTk.t, I_St_BTk.v, I_St_BTk.c};

  assign ld_vld    = I_Ld_FTk.v;
  assign cfg_sel   = boot_cnt - CNT_W'(BOOT_HDR);
  assign boot_last = (state == S_BOOT) && ld_vld && (boot_cnt == CNT_W'(BOOT_HDR + 4));
  assign st_done   = (state == S_ST) && !I_St_BTk.n;
  assign k_nxt     = k_idx + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (ld_vld && I_Ld_FTk.a) state_nxt = S_BOOT;
      S_BOOT: if (boot_last) state_nxt = (n_len == '0) ? S_DONE : S_LD_A;
      S_LD_A: state_nxt = S_WT_A;
      S_WT_A: if (ld_vld) state_nxt = S_LD_B;
      S_LD_B: state_nxt = S_WT_B;
      S_WT_B: if (ld_vld) state_nxt = S_MUL;
      S_MUL:  state_nxt = S_ST;
      S_ST:   if (st_done) state_nxt = (k_nxt == n_len) ? S_DONE : S_LD_A;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Boot capture: header words are counted but dropped, then five config words.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      boot_cnt <= '0;
      abase    <= '0;
      bbase    <= '0;
      sbase    <= '0;
      n_len    <= '0;
      k_mul    <= '0;
      k_idx    <= '0;
    end else begin
      if (state == S_IDLE && ld_vld && I_Ld_FTk.a) begin
        boot_cnt <= CNT_W'(1);
      end else if (state == S_BOOT && ld_vld) begin
        boot_cnt <= boot_cnt + 1'b1;
        if (boot_cnt >= CNT_W'(BOOT_HDR)) begin
          if (cfg_sel == CNT_W'(0)) abase <= I_Ld_FTk.d[WIDTH_EXADDR-1:0];
          if (cfg_sel == CNT_W'(1)) bbase <= I_Ld_FTk.d[WIDTH_EXADDR-1:0];
          if (cfg_sel == CNT_W'(2)) sbase <= I_Ld_FTk.d[WIDTH_EXADDR-1:0];
          if (cfg_sel == CNT_W'(3)) n_len <= I_Ld_FTk.d;
          if (cfg_sel == CNT_W'(4)) k_mul <= I_Ld_FTk.d;
        end
      end
      if (boot_last)    k_idx <= '0;
      else if (st_done) k_idx <= k_nxt;
    end
  end

  // p0: operands captured from the load port; p1: product held for the store.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ra_p0   <= '0;
      rb_p0   <= '0;
      prod_p1 <= '0;
    end else begin
      if (state == S_WT_A && ld_vld) ra_p0 <= I_Ld_FTk.d;
      if (state == S_WT_B && ld_vld) rb_p0 <= I_Ld_FTk.d;
      if (state == S_MUL)            prod_p1 <= mul_trunc(mul_trunc(ra_p0, rb_p0), k_mul);
    end
  end

  always_comb begin
    O_Ld_Req  = 1'b0;
    O_Ld_Addr = '0;
    O_Ld_BTk  = '0;
    O_St_Req  = 1'b0;
    O_St_Addr = '0;
    O_St_FTk  = '0;
    unique case (state)
      S_LD_A: begin
        O_Ld_Req  = 1'b1;
        O_Ld_Addr = abase + k_idx[WIDTH_EXADDR-1:0];
      end
      S_LD_B: begin
        O_Ld_Req  = 1'b1;
        O_Ld_Addr = bbase + k_idx[WIDTH_EXADDR-1:0];
      end
      S_ST: begin
        O_St_Req   = 1'b1;
        O_St_Addr  = sbase + k_idx[WIDTH_EXADDR-1:0];
        O_St_FTk.v = 1'b1;
        O_St_FTk.i = {WIDTH_INDEX{1'b0}};
        O_St_FTk.d = prod_p1;
      end
      S_DONE: O_Ld_BTk.t = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_electron_nest.sv
// Randomized scoreboard bench for electron_nest with a behavioural memory model.
module tb_electron_nest;
  import pkg_en::*;

  localparam int BOOT_HDR = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        I_Boot = 1'b0;
  logic        O_Ld_Req;
  logic [15:0] O_Ld_Addr;
  FTk_t        I_Ld_FTk;
  BTk_t        O_Ld_BTk;
  logic        O_St_Req;
  logic [15:0] O_St_Addr;
  FTk_t        O_St_FTk;
  BTk_t        I_St_BTk;

  electron_nest dut (
    .clock(clock), .reset(reset), .I_Boot(I_Boot),
    .O_Ld_Req(O_Ld_Req), .O_Ld_Addr(O_Ld_Addr), .I_Ld_FTk(I_Ld_FTk), .O_Ld_BTk(O_Ld_BTk),
    .O_St_Req(O_St_Req), .O_St_Addr(O_St_Addr), .O_St_FTk(O_St_FTk), .I_St_BTk(I_St_BTk)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        st;
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         ev_q[$];
  FTk_t        boot_q[$];
  logic [31:0] mem [0:65535];

  int vectors = 0, fails = 0;
  int t_count = 0, ld_cnt = 0, st_cnt = 0, hold_cnt = 0, bp_force = 0;
  int run_t0, run_l0, run_s0, run_n;
  bit pend = 0, running = 0, hold_chk = 0, gap_en = 0, spur_en = 0, bp_rand = 0;
  logic [15:0] pend_addr, hold_addr;
  logic [31:0] hold_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Memory model, boot-stream driver and scoreboard monitor, all on the falling edge.
  always @(negedge clock) begin
    FTk_t tok;
    ev_t  e;
    if (!reset) begin
      pend     = 1'b0;
      running  = 1'b0;
      hold_chk = 1'b0;
      I_Ld_FTk = '0;
      I_St_BTk = '0;
    end else begin
      if (hold_chk) begin
        chk("st_hold_req", 64'(O_St_Req), 64'd1);
        chk("st_hold_addr", 64'(O_St_Addr), 64'(hold_addr));
        chk("st_hold_data", 64'(O_St_FTk.d), 64'(hold_d));
        hold_chk = 1'b0;
        hold_cnt++;
      end
      if (O_Ld_BTk.t) begin
        t_count++;
        running = 1'b0;
      end

      tok = '0;
      if (pend) begin
        tok.v = 1'b1;
        tok.d = mem[pend_addr];
      end else if (boot_q.size() > 0) begin
        if (gap_en && $urandom_range(3) == 0) tok.d = $urandom;
        else begin
          tok = boot_q.pop_front();
          if (boot_q.size() == 0) running = 1'b1;
        end
      end else if (spur_en && running && $urandom_range(2) == 0) begin
        tok.v = 1'b1;
        tok.a = 1'b1;
        tok.i = 8'($urandom);
        tok.d = $urandom;
      end
      I_Ld_FTk  = tok;
      pend      = O_Ld_Req;
      pend_addr = O_Ld_Addr;

      if (O_Ld_Req) begin
        ld_cnt++;
        chk("ld_btk_n", 64'(O_Ld_BTk.n), 64'd0);
        if (ev_q.size() == 0 || ev_q[0].st) begin
          vectors++;
          fails++;
          $display("FAIL ld_order: load at 0x%0h, required no load here", O_Ld_Addr);
        end else begin
          e = ev_q.pop_front();
          chk("ld_addr", 64'(O_Ld_Addr), 64'(e.addr));
        end
      end

      if (O_St_Req && bp_force > 0) begin
        I_St_BTk.n = 1'b1;
        bp_force--;
      end else begin
        I_St_BTk.n = bp_rand ? 1'($urandom_range(1)) : 1'b0;
      end

      if (O_St_Req) begin
        if (I_St_BTk.n) begin
          hold_chk  = 1'b1;
          hold_addr = O_St_Addr;
          hold_d    = O_St_FTk.d;
        end else begin
          st_cnt++;
          mem[O_St_Addr] = O_St_FTk.d;
          if (ev_q.size() == 0 || !ev_q[0].st) begin
            vectors++;
            fails++;
            $display("FAIL st_order: store at 0x%0h, required no store here", O_St_Addr);
          end else begin
            e = ev_q.pop_front();
            chk("st_addr", 64'(O_St_Addr), 64'(e.addr));
            chk("st_tok", 64'(O_St_FTk), 64'({1'b1, 3'b000, 8'h00, e.data}));
          end
        end
      end
    end
  end

  // Reference model: each element is load A, load B, then one store of A*B*K mod 2^32.
  task automatic start_run(input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] sb,
                           input logic [31:0] n, input logic [31:0] k);
    logic [15:0] aa, ba, sa;
    logic [63:0] p;
    for (int j = 0; j < int'(n); j++) begin
      aa = ab + 16'(j);
      ba = bb + 16'(j);
      sa = sb + 16'(j);
      p  = 64'(mem[aa]) * 64'(mem[ba]);
      p  = 64'(p[31:0]) * 64'(k);
      ev_q.push_back('{st: 1'b0, addr: aa, data: 32'd0});
      ev_q.push_back('{st: 1'b0, addr: ba, data: 32'd0});
      ev_q.push_back('{st: 1'b1, addr: sa, data: p[31:0]});
    end
    run_t0 = t_count;
    run_l0 = ld_cnt;
    run_s0 = st_cnt;
    run_n  = int'(n);
    boot_q.push_back(FTk_t'{v: 1'b1, a: 1'b1, default: '0});
    for (int j = 1; j < BOOT_HDR; j++)
      boot_q.push_back(FTk_t'{v: 1'b1, a: 1'($urandom_range(1)), d: $urandom, default: '0});
    boot_q.push_back(FTk_t'{v: 1'b1, d: 32'(ab), default: '0});
    boot_q.push_back(FTk_t'{v: 1'b1, d: 32'(bb), default: '0});
    boot_q.push_back(FTk_t'{v: 1'b1, d: 32'(sb), default: '0});
    boot_q.push_back(FTk_t'{v: 1'b1, d: n, default: '0});
    boot_q.push_back(FTk_t'{v: 1'b1, d: k, default: '0});
  endtask

  task automatic end_run();
    int cyc = 0;
    while (t_count == run_t0 && cyc < 5000) begin
      @(posedge clock);
      cyc++;
    end
    repeat (4) @(posedge clock);
    chk("t_pulses", 64'(t_count - run_t0), 64'd1);
    chk("ld_count", 64'(ld_cnt - run_l0), 64'(2 * run_n));
    chk("st_count", 64'(st_cnt - run_s0), 64'(run_n));
    chk("events_left", 64'(ev_q.size()), 64'd0);
    ev_q.delete();
  endtask

  task automatic setup_basic();
    for (int j = 0; j < 4; j++) begin
      mem[16'h0100 + 16'(j)] = 32'(j + 1);
      mem[16'h0200 + 16'(j)] = 32'(j + 5);
      mem[16'h0300 + 16'(j)] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic check_basic(input string tag);
    logic [31:0] exp_v [4];
    exp_v = '{32'd15, 32'd36, 32'd63, 32'd96};
    for (int j = 0; j < 4; j++)
      chk(tag, 64'(mem[16'h0300 + 16'(j)]), 64'(exp_v[j]));
  endtask

  initial begin
    int cyc;
    logic [15:0] ab;
    logic [31:0] n, k;
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;

    #3 reset = 1'b0;
    #1 chk("reset_outs_zero",
           64'(|{O_Ld_Req, O_Ld_Addr, O_Ld_BTk, O_St_Req, O_St_Addr, O_St_FTk}), 64'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);

    setup_basic();
    start_run(16'h0100, 16'h0200, 16'h0300, 32'd4, 32'd3);
    end_run();
    check_basic("basic_mem");

    setup_basic();
    spur_en = 1'b1;
    gap_en  = 1'b1;
    start_run(16'h0100, 16'h0200, 16'h0300, 32'd4, 32'd3);
    end_run();
    spur_en = 1'b0;
    gap_en  = 1'b0;
    check_basic("spurious_mem");

    mem[16'h0100] = 32'h0001_0000;
    mem[16'h0200] = 32'h0001_0000;
    mem[16'h0300] = 32'h1234_5678;
    start_run(16'h0100, 16'h0200, 16'h0300, 32'd1, 32'd1);
    end_run();
    chk("overflow_zero", 64'(mem[16'h0300]), 64'h0);
    mem[16'h0100] = 32'hFFFF_FFFF;
    mem[16'h0200] = 32'd2;
    start_run(16'h0100, 16'h0200, 16'h0300, 32'd1, 32'd1);
    end_run();
    chk("overflow_wrap", 64'(mem[16'h0300]), 64'hFFFF_FFFE);

    setup_basic();
    begin
      int h0 = hold_cnt;
      bp_force = 3;
      start_run(16'h0100, 16'h0200, 16'h0300, 32'd4, 32'd3);
      end_run();
      chk("bp_hold_cycles", 64'(hold_cnt - h0), 64'd3);
    end
    check_basic("bp_mem");

    start_run(16'h0100, 16'h0200, 16'h0300, 32'd0, 32'd7);
    end_run();

    setup_basic();
    start_run(16'h0100, 16'h0200, 16'h0300, 32'd4, 32'd3);
    cyc = 0;
    while (ld_cnt - run_l0 < 6 && cyc < 2000) begin
      @(posedge clock);
      cyc++;
    end
    chk("midrun_reached_b2", 64'(ld_cnt - run_l0), 64'd6);
    #2 reset = 1'b0;
    #1 chk("midrun_outs_zero",
           64'(|{O_Ld_Req, O_Ld_Addr, O_Ld_BTk, O_St_Req, O_St_Addr, O_St_FTk}), 64'd0);
    ev_q.delete();
    boot_q.delete();
    run_s0 = st_cnt;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    repeat (6) @(posedge clock);
    chk("midrun_no_store", 64'(st_cnt - run_s0), 64'd0);
    chk("midrun_partial_mem", 64'(mem[16'h0302]), 64'hDEAD_BEEF);
    setup_basic();
    start_run(16'h0100, 16'h0200, 16'h0300, 32'd4, 32'd3);
    end_run();
    check_basic("after_reset_mem");

    for (int r = 0; r < 10; r++) begin
      ab = (r == 3) ? 16'hFFFE : 16'($urandom);
      n  = (r == 6) ? 32'd0 : 32'($urandom_range(8, 1));
      k  = $urandom;
      for (int j = 0; j < 8; j++) begin
        mem[ab + 16'(j)]           = $urandom;
        mem[ab + 16'h4000 + 16'(j)] = $urandom;
      end
      gap_en  = 1'($urandom_range(1));
      spur_en = 1'($urandom_range(1));
      bp_rand = 1'($urandom_range(1));
      start_run(ab, ab + 16'h4000, ab + 16'h8000, n, k);
      end_run();
    end
    gap_en  = 1'b0;
    spur_en = 1'b0;
    bp_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
